// File: rtl/avc_pkg.sv
// Shared definitions for the parametrised access vector cache:
// operation encoding and index-width helper.
package avc_pkg;

    typedef enum logic [1:0] {
        AVC_LOOKUP     = 2'b00,
        AVC_INSERT     = 2'b01,
        AVC_INVALIDATE = 2'b10,
        AVC_FLUSH      = 2'b11
    } avc_op_e;

    function automatic int idx_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/avc_match.sv
// Combinational tag matcher: finds the entry holding req_id and the
// lowest-index invalid entry.
import avc_pkg::*;

module avc_match #(
    parameter int ID_W  = 15,
    parameter int DEPTH = 8,
    parameter int IDX_W = idx_width(DEPTH)
) (
    input  logic [ID_W-1:0]  tags [DEPTH],
    input  logic [DEPTH-1:0] valids,
    input  logic [ID_W-1:0]  req_id,
    output logic             match_any,
    output logic [IDX_W-1:0] match_idx,
    output logic             free_any,
    output logic [IDX_W-1:0] free_idx
);

    // First hit wins in both scans, so the free slot is always the lowest index.
    always_comb begin
        match_any = 1'b0;
        match_idx = '0;
        free_any  = 1'b0;
        free_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!match_any && valids[i] && (tags[i] == req_id)) begin
                match_any = 1'b1;
                match_idx = IDX_W'(i);
            end
            if (!free_any && !valids[i]) begin
                free_any = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/avc_param.sv
// Parametrised access vector cache: fully associative ID-to-permission
// store with insert/invalidate/flush, round-robin replacement and hit/miss stats.
import avc_pkg::*;

module avc_param #(
    parameter int ID_W   = 15,
    parameter int PERM_W = 2,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [1:0]        req_op,
    input  logic [ID_W-1:0]   req_id,
    input  logic [PERM_W-1:0] req_perm,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic              rsp_hit,
    output logic [PERM_W-1:0] rsp_perm,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam int IDX_W = idx_width(DEPTH);

    logic [ID_W-1:0]   tags  [DEPTH];
    logic [PERM_W-1:0] perms [DEPTH];
    logic [DEPTH-1:0]  valids;
    logic [IDX_W-1:0]  rr_ptr;
    logic              ready_q;

    logic              match_any;
    logic [IDX_W-1:0]  match_idx;
    logic              free_any;
    logic [IDX_W-1:0]  free_idx;
    logic              accept;
    avc_op_e           op;

    assign req_ready = ready_q;
    assign accept    = req_valid && ready_q;
    assign op        = avc_op_e'(req_op);

    avc_match #(
        .ID_W  (ID_W),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_match (
        .tags      (tags),
        .valids    (valids),
        .req_id    (req_id),
        .match_any (match_any),
        .match_idx (match_idx),
        .free_any  (free_any),
        .free_idx  (free_idx)
    );

    // Array and response both update on the accepting edge, so the next
    // request already sees this one's effect.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tags[i]  <= '0;
                perms[i] <= '0;
            end
            valids    <= '0;
            rr_ptr    <= '0;
            ready_q   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_hit   <= 1'b0;
            rsp_perm  <= '0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
        end else begin
            ready_q   <= 1'b1;
            rsp_valid <= accept;
            rsp_hit   <= 1'b0;
            rsp_perm  <= '0;
            if (accept) begin
                case (op)
                    AVC_LOOKUP: begin
                        if (match_any) begin
                            rsp_hit  <= 1'b1;
                            rsp_perm <= perms[match_idx];
                            if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
                        end else begin
                            if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
                        end
                    end
                    AVC_INSERT: begin
                        if (match_any) begin
                            rsp_hit          <= 1'b1;
                            rsp_perm         <= perms[match_idx];
                            perms[match_idx] <= req_perm;
                        end else if (free_any) begin
                            tags[free_idx]   <= req_id;
                            perms[free_idx]  <= req_perm;
                            valids[free_idx] <= 1'b1;
                        end else begin
                            tags[rr_ptr]  <= req_id;
                            perms[rr_ptr] <= req_perm;
                            rr_ptr <= (rr_ptr == IDX_W'(DEPTH - 1)) ? '0 : rr_ptr + 1'b1;
                        end
                    end
                    AVC_INVALIDATE: begin
                        if (match_any) begin
                            rsp_hit           <= 1'b1;
                            rsp_perm          <= perms[match_idx];
                            valids[match_idx] <= 1'b0;
                        end
                    end
                    AVC_FLUSH: begin
                        valids <= '0;
                        rr_ptr <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_avc_param.sv
// Directed scoreboard bench for avc_param; a second instance with CNT_W=2
// shares the stimulus to exercise counter saturation.
import avc_pkg::*;

module tb_avc_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [1:0]  req_op;
    logic [14:0] req_id;
    logic [1:0]  req_perm;
    logic        req_ready, rsp_valid, rsp_hit;
    logic [1:0]  rsp_perm;
    logic [15:0] hit_cnt, miss_cnt;
    logic        s_ready, s_valid, s_hit;
    logic [1:0]  s_perm;
    logic [1:0]  s_hit_cnt, s_miss_cnt;

    typedef struct {
        logic       hit;
        logic [1:0] perm;
    } exp_t;

    exp_t        sb [$];
    int          checks = 0;
    int          errors = 0;

    logic [14:0] m_tag   [8];
    logic [1:0]  m_perm  [8];
    logic        m_valid [8];
    int          m_rr;
    int          m_hit;
    int          m_miss;

    always #5 clk = ~clk;

    avc_param dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_id    (req_id),
        .req_perm  (req_perm),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_hit   (rsp_hit),
        .rsp_perm  (rsp_perm),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
    );

    avc_param #(.CNT_W(2)) dut_small (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_id    (req_id),
        .req_perm  (req_perm),
        .req_ready (s_ready),
        .rsp_valid (s_valid),
        .rsp_hit   (s_hit),
        .rsp_perm  (s_perm),
        .hit_cnt   (s_hit_cnt),
        .miss_cnt  (s_miss_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 8; i++) begin
            m_tag[i] = '0; m_perm[i] = '0; m_valid[i] = 1'b0;
        end
        m_rr = 0; m_hit = 0; m_miss = 0;
        sb.delete();
    endtask

    task automatic modelAccess(input logic [1:0] op, input logic [14:0] id, input logic [1:0] perm,
                               output logic hit, output logic [1:0] rperm);
        int mi = -1;
        int fi = -1;
        for (int i = 0; i < 8; i++) begin
            if (mi < 0 && m_valid[i] && m_tag[i] == id) mi = i;
            if (fi < 0 && !m_valid[i]) fi = i;
        end
        hit   = (mi >= 0) && (op != 2'b11);
        rperm = hit ? m_perm[mi] : 2'b00;
        case (op)
            2'b00: if (mi >= 0) m_hit++; else m_miss++;
            2'b01: begin
                if (mi >= 0) m_perm[mi] = perm;
                else if (fi >= 0) begin
                    m_tag[fi] = id; m_perm[fi] = perm; m_valid[fi] = 1'b1;
                end else begin
                    m_tag[m_rr] = id; m_perm[m_rr] = perm;
                    m_rr = (m_rr + 1) % 8;
                end
            end
            2'b10: if (mi >= 0) m_valid[mi] = 1'b0;
            default: begin
                for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
                m_rr = 0;
            end
        endcase
    endtask

    task automatic checkCounters();
        check("hit_cnt", 32'(hit_cnt), 32'(sat(m_hit, 65535)));
        check("miss_cnt", 32'(miss_cnt), 32'(sat(m_miss, 65535)));
        check("small_hit_cnt", 32'(s_hit_cnt), 32'(sat(m_hit, 3)));
        check("small_miss_cnt", 32'(s_miss_cnt), 32'(sat(m_miss, 3)));
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_nonempty", 32'(0), 32'(1));
            return;
        end
        e = sb.pop_front();
        check("rsp_valid", 32'(rsp_valid), 32'(1));
        check("rsp_hit", 32'(rsp_hit), 32'(e.hit));
        check("rsp_perm", 32'(rsp_perm), 32'(e.perm));
        check("small_rsp_hit", 32'(s_hit), 32'(e.hit));
        checkCounters();
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [14:0] id, input logic [1:0] perm);
        exp_t e;
        check("req_ready", 32'(req_ready), 32'(1));
        req_valid = 1'b1;
        req_op    = op;
        req_id    = id;
        req_perm  = perm;
        modelAccess(op, id, perm, e.hit, e.perm);
        sb.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic goIdle();
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("idle_rsp_valid", 32'(rsp_valid), 32'(0));
        check("idle_rsp_hit", 32'(rsp_hit), 32'(0));
        check("idle_rsp_perm", 32'(rsp_perm), 32'(0));
    endtask

    initial begin
        modelReset();
        rst       = 1'b1;
        req_valid = 1'b1;
        req_op    = AVC_LOOKUP;
        req_id    = 15'h1234;
        req_perm  = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", 32'(req_ready), 32'(0));
        check("reset_rsp_valid", 32'(rsp_valid), 32'(0));
        checkCounters();
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_reset", 32'(req_ready), 32'(1));
        check("dropped_during_reset", 32'(rsp_valid), 32'(0));
        goIdle();

        applyStimulus(AVC_LOOKUP, 15'h1234, 2'b00);
        check("first_miss_cnt", 32'(miss_cnt), 32'(1));
        goIdle();

        applyStimulus(AVC_INSERT, 15'h0011, 2'b10);
        applyStimulus(AVC_LOOKUP, 15'h0011, 2'b00);
        check("first_hit_perm", 32'(rsp_perm), 32'(2'b10));
        check("first_hit_cnt", 32'(hit_cnt), 32'(1));
        applyStimulus(AVC_INSERT, 15'h0011, 2'b01);
        check("update_old_perm", 32'(rsp_perm), 32'(2'b10));
        applyStimulus(AVC_LOOKUP, 15'h0011, 2'b00);
        applyStimulus(AVC_INVALIDATE, 15'h0011, 2'b00);
        applyStimulus(AVC_LOOKUP, 15'h0011, 2'b00);
        goIdle();

        applyStimulus(AVC_FLUSH, 15'h0000, 2'b00);
        for (int k = 1; k <= 8; k++) applyStimulus(AVC_INSERT, 15'(k), 2'(k));
        applyStimulus(AVC_INSERT, 15'd9, 2'b11);
        applyStimulus(AVC_LOOKUP, 15'd1, 2'b00);
        applyStimulus(AVC_LOOKUP, 15'd9, 2'b00);
        applyStimulus(AVC_INSERT, 15'd10, 2'b01);
        applyStimulus(AVC_LOOKUP, 15'd2, 2'b00);
        applyStimulus(AVC_LOOKUP, 15'd3, 2'b00);

        applyStimulus(AVC_INVALIDATE, 15'd5, 2'b00);
        applyStimulus(AVC_INSERT, 15'd20, 2'b10);
        applyStimulus(AVC_LOOKUP, 15'd20, 2'b00);
        applyStimulus(AVC_LOOKUP, 15'd5, 2'b00);
        applyStimulus(AVC_INSERT, 15'd21, 2'b01);
        applyStimulus(AVC_LOOKUP, 15'd3, 2'b00);
        applyStimulus(AVC_LOOKUP, 15'd4, 2'b00);
        applyStimulus(AVC_INVALIDATE, 15'h0999, 2'b00);
        goIdle();

        applyStimulus(AVC_FLUSH, 15'h0000, 2'b00);
        applyStimulus(AVC_LOOKUP, 15'd9, 2'b00);
        applyStimulus(AVC_LOOKUP, 15'd20, 2'b00);
        applyStimulus(AVC_LOOKUP, 15'd4, 2'b00);
        for (int k = 30; k <= 38; k++) applyStimulus(AVC_INSERT, 15'(k), 2'(k));
        applyStimulus(AVC_LOOKUP, 15'd30, 2'b00);
        applyStimulus(AVC_LOOKUP, 15'd38, 2'b00);
        applyStimulus(AVC_LOOKUP, 15'd31, 2'b00);
        goIdle();

        req_valid = 1'b1;
        req_op    = AVC_INSERT;
        req_id    = 15'h0077;
        req_perm  = 2'b11;
        rst       = 1'b1;
        modelReset();
        @(posedge clk);
        #1;
        check("midop_rsp_valid", 32'(rsp_valid), 32'(0));
        check("midop_rsp_hit", 32'(rsp_hit), 32'(0));
        check("midop_rsp_perm", 32'(rsp_perm), 32'(0));
        check("midop_ready", 32'(req_ready), 32'(0));
        checkCounters();
        rst       = 1'b0;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("midop_ready_back", 32'(req_ready), 32'(1));
        check("midop_no_rsp", 32'(rsp_valid), 32'(0));
        applyStimulus(AVC_LOOKUP, 15'h0077, 2'b00);
        goIdle();

        check("scoreboard_drained", 32'(sb.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/avc_param.md
Name: avc_param

Overview:
Parametrised access vector cache (AVC), the successor to the fixed 8-entry, 15-bit-ID permission cache.
- Caches ID-to-permission mappings for the firewall datapath, in a fully associative array with per-entry valid bits.
- Supports four operations: lookup, insert-or-update, single-entry invalidate and full flush.
- Replacement prefers invalid entries first, then round-robin.
- Keeps saturating hit/miss statistics.
- Sits between the policy engine, which inserts and invalidates, and the request checker, which looks up.

Parameters:
- ID_W, 15, width of the requester/process ID tag.
- PERM_W, 2, width of the permission field.
- DEPTH, 8, number of cache entries; must be >= 2.
- CNT_W, 16, width of the hit/miss statistics counters.

Ports:
- clk  input  1  single clock; everything is sampled on its rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request strobe.
- req_op  input  2  operation: 00 LOOKUP, 01 INSERT, 10 INVALIDATE, 11 FLUSH.
- req_id  input  ID_W  tag for LOOKUP, INSERT or INVALIDATE.
- req_perm  input  PERM_W  permission written by INSERT.
- req_ready  output  1  block can accept a request this cycle.
- rsp_valid  output  1  one-cycle pulse; response fields are valid.
- rsp_hit  output  1  tag was present at the time of the access.
- rsp_perm  output  PERM_W  permission of the hit entry, or 0 on a miss.
- hit_cnt  output  CNT_W  saturating count of LOOKUP hits.
- miss_cnt  output  CNT_W  saturating count of LOOKUP misses.

Behaviour:
- Reset (rst=1 at a clock edge):
  - All valid bits, tags and perms go to 0; rr_ptr goes to 0.
  - rsp_valid, rsp_hit, rsp_perm, hit_cnt and miss_cnt go to 0.
  - req_ready is 0 during reset and 1 from the first edge with rst=0.
  - A request presented during reset is dropped, with no response.
  - Reset in the middle of any operation discards it: its response is not emitted.
- Acceptance:
  - A request is accepted when req_valid && req_ready.
  - Throughput is one request per cycle; there is no response backpressure.
- Response timing:
  - The response appears on the edge that accepts the request, so it is visible in the following cycle: rsp_valid=1 for exactly one cycle.
  - Idle cycles drive rsp_valid=0, rsp_hit=0 and rsp_perm=0.
- Match:
  - Entry i matches when valid[i] && tag[i]==req_id.
  - By construction at most one entry matches: INSERT never duplicates a tag.
- LOOKUP:
  - Hit: rsp_hit=1, rsp_perm=perm of the matching entry, hit_cnt+1.
  - Miss: rsp_hit=0, rsp_perm=0, miss_cnt+1.
  - Both counters saturate at 2^CNT_W-1, with no wrap.
- INSERT:
  - Tag already present: overwrite that entry's perm in place. rsp_hit=1, rsp_perm=old perm, rr_ptr unchanged.
  - Tag absent, some entry invalid: write the lowest-index invalid entry and set it valid. rsp_hit=0, rr_ptr unchanged.
  - Tag absent, array full: write entry rr_ptr; rr_ptr becomes (rr_ptr==DEPTH-1) ? 0 : rr_ptr+1. rsp_hit=0.
  - Statistics are unchanged.
- INVALIDATE:
  - Matching entry: clear its valid bit; rsp_hit=1, rsp_perm=its perm.
  - No match: no state change; rsp_hit=0.
  - rr_ptr is unchanged. Statistics are unchanged.
- FLUSH:
  - Clears all valid bits and sets rr_ptr to 0, in a single cycle.
  - rsp_hit=0. Statistics are kept; only rst clears them.
- Back-to-back ordering:
  - Array state updates on the accepting edge.
  - A request in cycle N+1 therefore sees the effects of the request in cycle N: an INSERT followed by a LOOKUP of the same ID hits.
- Widths: all index arithmetic uses $clog2(DEPTH) bits. The DEPTH-1 wrap is explicit, so non-power-of-2 DEPTH is legal.

Decomposition:
- Package avc_pkg:
  - Op encoding enum: AVC_LOOKUP, AVC_INSERT, AVC_INVALIDATE, AVC_FLUSH.
  - Helper function for index width, $clog2(DEPTH).
- Sub-module avc_match (purely combinational):
  - Inputs: tags, valids, req_id.
  - Outputs: match_any, match_idx, free_any, free_idx (lowest index).
- avc_param holds:
  - The storage, rr_ptr, counters and response registers.
  - The per-op update logic.

Test Plan:
- Reset, then LOOKUP id 0x1234 → rsp_valid=1 next cycle, rsp_hit=0, rsp_perm=0, miss_cnt=1, hit_cnt=0.
- INSERT 0x0011/perm 2'b10, then LOOKUP 0x0011 in the immediately following cycle → rsp_hit=1, rsp_perm=2'b10, hit_cnt=1.
- INSERT 0x0011/2'b01 over an existing entry → rsp_hit=1, rsp_perm=2'b10 (old value). Then LOOKUP → 2'b01. Exactly one entry holds the tag; rr_ptr stays 0.
- Fill 8 distinct IDs 1..8 (entries 0..7), then INSERT ID 9 → replaces entry 0, so LOOKUP 1 misses and LOOKUP 9 hits. Then INSERT ID 10 → replaces entry 1 (rr_ptr=2).
- With 8 valid entries, INVALIDATE ID 5 → rsp_hit=1. A new INSERT ID 20 lands in entry 4 (the freed slot) and rr_ptr is unchanged. Then FLUSH → every subsequent LOOKUP misses.
- CNT_W=2 build, 5 LOOKUP misses → miss_cnt stays at 3. Assert rst during a pending INSERT → no rsp_valid, all outputs 0, and the inserted ID misses afterwards.
